// File: rtl/gon_collect.sv
// rtl/gon_collect.sv - tag-matched collector from a PE array into a one-entry SRAM output buffer
// Scan-loaded row/column IDs select one PE; its word is handed to the SRAM through a registered buffer.
module gon_collect #(
  parameter int NUMS_PE_ROW = 6,
  parameter int NUMS_PE_COL = 8,
  parameter int XID_BITS    = 5,
  parameter int YID_BITS    = 4,
  parameter int DATA_BITS   = 32
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]             PE_valid,
  output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]             PE_ready,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL*DATA_BITS-1:0]   PE_data,
  input  logic [XID_BITS-1:0]                            tag_X,
  input  logic [YID_BITS-1:0]                            tag_Y,
  input  logic                                           set_XID,
  input  logic [XID_BITS-1:0]                            XID_scan_in,
  input  logic                                           set_YID,
  input  logic [YID_BITS-1:0]                            YID_scan_in,
  output logic                                           GON_valid,
  input  logic                                           GON_ready,
  output logic [DATA_BITS-1:0]                           GON_data,
  output logic                                           GON_multi_hit
);
  localparam int NPE = NUMS_PE_ROW * NUMS_PE_COL;
  localparam logic [NPE-1:0] ONE = NPE'(1);

  logic [NUMS_PE_ROW-1:0][YID_BITS-1:0] yid_q, yid_d;
  logic [NPE-1:0][XID_BITS-1:0]         xid_q, xid_d;
  logic                                 full_q, full_d;
  logic [DATA_BITS-1:0]                 data_q, data_d;
  logic                                 multi_q, multi_d;

  logic [NPE-1:0]       match;
  logic [NPE-1:0]       sel_oh;
  logic [DATA_BITS-1:0] sel_data;
  logic                 accept;
  logic                 capture;

  for (genvar k = 0; k < NPE; k++) begin : g_match
    assign match[k] = (yid_q[k / NUMS_PE_COL] == tag_Y) && (xid_q[k] == tag_X);
  end

  // Lowest-index match wins; isolate its bit and mux its word.
  always_comb begin
    sel_oh   = match & ~(match - ONE);
    sel_data = '0;
    for (int k = 0; k < NPE; k++) begin
      sel_data = sel_data | ({DATA_BITS{sel_oh[k]}} & PE_data[k*DATA_BITS +: DATA_BITS]);
    end
  end

  assign accept   = !full_q || GON_ready;
  assign PE_ready = (rst && accept) ? sel_oh : '0;
  assign capture  = |(PE_valid & PE_ready);

  always_comb begin
    yid_d = yid_q;
    if (set_YID) begin
      yid_d[0] = YID_scan_in;
      for (int r = 1; r < NUMS_PE_ROW; r++) yid_d[r] = yid_q[r-1];
    end
    xid_d = xid_q;
    if (set_XID) begin
      xid_d[0] = XID_scan_in;
      for (int k = 1; k < NPE; k++) xid_d[k] = xid_q[k-1];
    end
    full_d = full_q;
    data_d = data_q;
    if (capture) begin
      full_d = 1'b1;
      data_d = sel_data;
    end else if (full_q && GON_ready) begin
      full_d = 1'b0;
    end
    // Two or more matches are only flagged once some matching PE actually offers data.
    multi_d = multi_q || ((|(match & (match - ONE))) && (|(match & PE_valid)));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      yid_q   <= '0;
      xid_q   <= '0;
      full_q  <= 1'b0;
      data_q  <= '0;
      multi_q <= 1'b0;
    end else begin
      yid_q   <= yid_d;
      xid_q   <= xid_d;
      full_q  <= full_d;
      data_q  <= data_d;
      multi_q <= multi_d;
    end
  end

  assign GON_valid     = full_q;
  assign GON_data      = data_q;
  assign GON_multi_hit = multi_q;
endmodule

// File: tb/tb_gon_collect.sv
// tb/tb_gon_collect.sv - directed and randomized checks of gon_collect against a behavioural model
module tb_gon_collect;
  localparam int NPE = 48;

  logic             clk = 1'b0;
  logic             rst;
  logic [NPE-1:0]   PE_valid;
  logic [NPE-1:0]   PE_ready;
  logic [NPE*32-1:0] PE_data;
  logic [4:0]       tag_X;
  logic [3:0]       tag_Y;
  logic             set_XID;
  logic [4:0]       XID_scan_in;
  logic             set_YID;
  logic [3:0]       YID_scan_in;
  logic             GON_valid;
  logic             GON_ready;
  logic [31:0]      GON_data;
  logic             GON_multi_hit;

  gon_collect dut (
    .clk(clk), .rst(rst), .PE_valid(PE_valid), .PE_ready(PE_ready), .PE_data(PE_data),
    .tag_X(tag_X), .tag_Y(tag_Y), .set_XID(set_XID), .XID_scan_in(XID_scan_in),
    .set_YID(set_YID), .YID_scan_in(YID_scan_in), .GON_valid(GON_valid),
    .GON_ready(GON_ready), .GON_data(GON_data), .GON_multi_hit(GON_multi_hit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state: ID tables and the output buffer contents.
  logic [4:0]     mx[NPE];
  logic [3:0]     my[6];
  logic           m_full = 1'b0;
  logic [31:0]    m_data = '0;
  logic           m_multi = 1'b0;
  int             m_sel;
  int             m_nmatch;
  logic [NPE-1:0] exp_ready;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_comb();
    m_sel = -1;
    m_nmatch = 0;
    for (int k = 0; k < NPE; k++) begin
      if (my[k/8] == tag_Y && mx[k] == tag_X) begin
        m_nmatch++;
        if (m_sel < 0) m_sel = k;
      end
    end
    exp_ready = '0;
    if (rst && m_sel >= 0 && (!m_full || GON_ready)) exp_ready[m_sel] = 1'b1;
  endtask

  task automatic model_update();
    bit cap, anyv;
    model_comb();
    if (!rst) begin
      foreach (mx[k]) mx[k] = '0;
      foreach (my[r]) my[r] = '0;
      m_full = 0; m_data = '0; m_multi = 0;
    end else begin
      cap = (m_sel >= 0) && exp_ready[m_sel] && PE_valid[m_sel];
      anyv = 0;
      for (int k = 0; k < NPE; k++)
        if (my[k/8] == tag_Y && mx[k] == tag_X && PE_valid[k]) anyv = 1;
      if (m_nmatch >= 2 && anyv) m_multi = 1;
      if (cap) begin
        m_full = 1;
        m_data = PE_data[m_sel*32 +: 32];
      end else if (GON_ready) begin
        m_full = 0;
      end
      if (set_XID) begin
        for (int k = NPE-1; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = XID_scan_in;
      end
      if (set_YID) begin
        for (int r = 5; r > 0; r--) my[r] = my[r-1];
        my[0] = YID_scan_in;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_comb();
    chk("pe_ready", 64'(PE_ready), 64'(exp_ready));
    chk("gon_valid", 64'(GON_valid), 64'(m_full));
    chk("gon_data", 64'(GON_data), 64'(m_data));
    chk("multi_hit", 64'(GON_multi_hit), 64'(m_multi));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic scan_ids(input bit pair_3_9);
    set_XID = 1;
    for (int i = 47; i >= 0; i--) begin
      XID_scan_in = (pair_3_9 && i == 9) ? 5'd3 : 5'(i);
      step();
    end
    set_XID = 0;
    set_YID = 1;
    for (int i = 5; i >= 0; i--) begin
      YID_scan_in = (pair_3_9 && i == 1) ? 4'd0 : 4'(i);
      step();
    end
    set_YID = 0;
  endtask

  initial begin
    foreach (mx[k]) mx[k] = '0;
    foreach (my[r]) my[r] = '0;
    rst = 0; PE_valid = '0; PE_data = '0; tag_X = '0; tag_Y = '0;
    set_XID = 0; XID_scan_in = '0; set_YID = 0; YID_scan_in = '0; GON_ready = 1;
    step(); step();
    rst = 1;
    scan_ids(0);

    // Single PE 17 transfer.
    tag_Y = 4'd2; tag_X = 5'd17;
    PE_valid = '0; PE_valid[17] = 1'b1;
    PE_data[17*32 +: 32] = 32'hA5A5_0011;
    #1 chk("sel17_ready", 64'(PE_ready), 64'(48'h1 << 17));
    step();
    chk("sel17_valid", 64'(GON_valid), 64'd1);
    chk("sel17_data", 64'(GON_data), 64'hA5A5_0011);

    // Backpressure for three cycles, then drain and capture together.
    GON_ready = 0;
    PE_data[17*32 +: 32] = 32'hBEEF_0002;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_data", 64'(GON_data), 64'hA5A5_0011);
    end
    GON_ready = 1;
    step();
    chk("drain_cap_valid", 64'(GON_valid), 64'd1);
    chk("drain_cap_data", 64'(GON_data), 64'hBEEF_0002);

    // Eight-word burst at full rate.
    for (int i = 0; i < 8; i++) begin
      PE_data[17*32 +: 32] = 32'hC0DE_0000 + 32'(i);
      step();
      chk("burst_valid", 64'(GON_valid), 64'd1);
      chk("burst_data", 64'(GON_data), 64'hC0DE_0000 + 64'(i));
    end

    // No-match tags.
    tag_Y = 4'd7; PE_valid = '1;
    #1 chk("nomatch_ready", 64'(PE_ready), 64'd0);
    step(); step();
    chk("nomatch_valid", 64'(GON_valid), 64'd0);

    // PEs 3 and 9 share IDs.
    PE_valid = '0;
    scan_ids(1);
    tag_X = 5'd3; tag_Y = 4'd0;
    PE_valid[3] = 1; PE_valid[9] = 1;
    PE_data[3*32 +: 32] = 32'h3333_3333;
    PE_data[9*32 +: 32] = 32'h9999_9999;
    #1 chk("pair_ready", 64'(PE_ready), 64'(48'h8));
    step();
    chk("pair_data", 64'(GON_data), 64'h3333_3333);
    chk("pair_multi", 64'(GON_multi_hit), 64'd1);

    // Reset while FULL.
    GON_ready = 0;
    rst = 0;
    #1 chk("rst_ready", 64'(PE_ready), 64'd0);
    step();
    rst = 1;
    chk("rst_valid", 64'(GON_valid), 64'd0);
    chk("rst_data", 64'(GON_data), 64'd0);
    chk("rst_multi", 64'(GON_multi_hit), 64'd0);
    tag_X = '0; tag_Y = '0; PE_valid = '0;
    #1 chk("rst_ids_zero", 64'(PE_ready), 64'd1);
    step();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom % 64) != 0;
      set_XID = ($urandom % 40) == 0;
      XID_scan_in = 5'($urandom % 48);
      set_YID = ($urandom % 40) == 0;
      YID_scan_in = 4'($urandom % 6);
      tag_X = 5'($urandom % 48);
      tag_Y = ($urandom % 4 != 0) ? 4'(tag_X / 8) : 4'($urandom % 8);
      PE_valid = {16'($urandom), 32'($urandom)};
      for (int k = 0; k < NPE; k++) PE_data[k*32 +: 32] = $urandom;
      GON_ready = ($urandom % 3) != 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
